// File: rtl/my_timer_irq_ctrl.sv
// Interrupt aggregator for timer irq lines, with an Avalon-MM register file.
// Define MY_TIMER_IRQ_CTRL_SYNC_EN to pass irq_in through a 2-flop synchronizer first.
module my_timer_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_ENABLE  = 3'd1;
  localparam logic [2:0] A_MODE    = 3'd2;
  localparam logic [2:0] A_ACTIVE  = 3'd3;
  localparam logic [2:0] A_VECTOR  = 3'd4;
  localparam logic [2:0] A_SWTRIG  = 3'd5;

  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_hist;
  logic [NUM_IRQ-1:0] w_src;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_set;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_active;
  logic [15:0]        w_vector;
  logic [15:0]        w_rdata;
  logic               w_write;

  assign w_write  = chipselect & ~write_n;
  assign w_wdata  = writedata[NUM_IRQ-1:0];
  assign w_active = r_pending & r_enable;

`ifdef MY_TIMER_IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  // Two-stage synchronizer for asynchronous timer sources
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_in;
`endif

  // Per-bit set/clear requests; ENABLE deliberately plays no part in setting
  always_comb begin
    w_set = (r_mode & w_src & ~r_hist) | (~r_mode & w_src);
    w_clr = '0;
    if (w_write && (address == A_SWTRIG)) begin
      w_set = w_set | w_wdata;
    end else begin
      w_set = w_set;
    end
    if (w_write && (address == A_PENDING)) begin
      w_clr = w_wdata;
    end else begin
      w_clr = '0;
    end
  end

  // Lowest active index wins; scanning from the top lets the low bits override
  always_comb begin
    w_vector = 16'h0000;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vector = {1'b1, 11'h000, 4'(i)};
      end else begin
        w_vector = w_vector;
      end
    end
  end

  // Read mux; unimplemented bits zero-extend
  always_comb begin
    w_rdata = 16'h0000;
    case (address)
      A_PENDING: w_rdata = 16'(r_pending);
      A_ENABLE:  w_rdata = 16'(r_enable);
      A_MODE:    w_rdata = 16'(r_mode);
      A_ACTIVE:  w_rdata = 16'(w_active);
      A_VECTOR:  w_rdata = w_vector;
      default:   w_rdata = 16'h0000;
    endcase
  end

  // Pending latch: a set in the same cycle as W1C survives the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_hist    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_hist    <= w_src;
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= '0;
      r_mode   <= '0;
    end else begin
      if (w_write && (address == A_ENABLE)) begin
        r_enable <= w_wdata;
      end else begin
        r_enable <= r_enable;
      end
      if (w_write && (address == A_MODE)) begin
        r_mode <= w_wdata;
      end else begin
        r_mode <= r_mode;
      end
    end
  end

  // Registered bus and CPU outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      readdata <= w_rdata;
      irq      <= |w_active;
    end
  end

endmodule

// File: doc/my_timer_irq_ctrl.md
MY_TIMER_IRQ_CTRL -- requirements
Module: my_timer_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of interrupt inputs (legal 1..16).
REQ-002 SHALL have clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have address  input  3  Avalon-MM word address.
REQ-005 SHALL have chipselect  input  1  slave select.
REQ-006 SHALL have write_n  input  1  write strobe, active-low.
REQ-007 SHALL have writedata  input  16  write data.
REQ-008 SHALL have readdata  output  16  registered read data.
REQ-009 SHALL have irq_in  input  NUM_IRQ  interrupt sources (timer irq outputs), bit 0 highest priority.
REQ-010 SHALL have irq  output  1  aggregated interrupt request to CPU, active-high.

Function
REQ-011 SHALL decode write = chipselect & ~write_n; reads need no strobe.
REQ-012 SHALL implement the register map: 0 PENDING (R, W1C); 1 ENABLE (RW); 2 MODE (RW, 1=edge, 0=level); 3 ACTIVE = PENDING & ENABLE (RO); 4 VECTOR (RO: bit15 valid, bits3:0 index); 5 SWTRIG (WO, write-1 sets PENDING); 6-7 reserved.
REQ-013 SHALL register readdata every cycle from the address-selected value: 1-cycle read latency.
REQ-014 SHALL read 0 for reserved addresses, SWTRIG, and bits >= NUM_IRQ; writes to those bits ignored.
REQ-015 SHALL, in edge mode, keep a 1-cycle history flop per input; PENDING[i] set when irq_in[i]=1 and history=0.
REQ-016 SHALL, in level mode, set PENDING[i] every cycle irq_in[i]=1; W1C clears it for one cycle only while source stays high.
REQ-017 SHALL give set priority over clear when set (edge, level or SWTRIG) and W1C hit the same bit in the same cycle.
REQ-018 SHALL compute VECTOR as lowest index i with ACTIVE[i]=1, valid=1; if ACTIVE=0, VECTOR reads 0x0000.
REQ-019 SHALL register irq <= |ACTIVE; irq_in rise at edge k gives PENDING at k+1, irq at k+2.
REQ-020 SHALL ignore ENABLE when setting PENDING: masked sources still latch and assert irq once enabled.
REQ-021 SHALL apply MODE changes on the next cycle; no PENDING change from the write itself.

Reset
REQ-022 SHALL asynchronously clear PENDING, ENABLE, MODE, edge history, readdata and irq to 0 on reset_n=0.
REQ-023 SHALL, after reset release, treat an input already high as a rising edge in edge mode (history reset 0), so held timer irq is not lost.
REQ-024 SHALL abort any in-flight read on reset; first read after release returns valid data after 1 cycle.

Configuration
REQ-025 SHALL support macro MY_TIMER_IRQ_CTRL_SYNC_EN: when defined, irq_in passes a 2-flop synchronizer (reset 0) before edge/level logic, adding 2 cycles (irq at k+4); when undefined, irq_in is used directly (irq at k+2).

Verification
REQ-026 Edge: MODE=0x01, ENABLE=0x01, irq_in[0] 0->1 held -> PENDING=0x0001 once, irq=1 two cycles after edge; W1C 0x0001 -> irq=0, no re-set while held.
REQ-027 Level: MODE=0, ENABLE=0x04, irq_in[2] held high, W1C 0x0004 -> PENDING bit2 reads 1 again next cycle, irq stays 1; deassert input then W1C -> irq=0.
REQ-028 Priority: ENABLE=0xFF, SWTRIG 0x28 -> VECTOR=0x8003; W1C 0x08 -> VECTOR=0x8005; W1C 0x20 -> VECTOR=0x0000, irq=0.
REQ-029 Collision: edge on irq_in[1] in same cycle as W1C 0x0002 -> PENDING bit1=1.
REQ-030 Mask: ENABLE=0, edge on irq_in[4] -> PENDING=0x0010, irq=0; write ENABLE=0x10 -> irq=1 two cycles later.
REQ-031 Reset: irq_in[0]=1 held, MODE=0x01 restored after reset pulse mid-operation -> all registers 0 during reset, PENDING bit0 set after release; repeat with MY_TIMER_IRQ_CTRL_SYNC_EN and check +2 cycle latency.
